// File: rtl/thread_command_sequencer.sv
// thread_command_sequencer
//   Consumer side of one thread's register block. Polls the control word over
//   port B for a start request, clears it, marks the thread busy, then fetches
//   each 3-word command, hands it to the execution pipeline over valid/ready
//   and reports progress and completion in the status word.
//
// Ports
//   clk             single clock (register block port B shares it)
//   reset           synchronous, active-high
//   port_b_address  byte address into the register block
//   port_b_rd_en    read strobe; data returns on the following cycle
//   port_b_rd_data  read data from the register block
//   port_b_wr_data  write data
//   port_b_wr_en    per-byte write enables
//   cmd_valid       command presented to the execution pipeline
//   cmd_ready       execution pipeline accepts the command
//   cmd_data        {word2, word1, word0} of the current command
//   busy            high from the start-bit clear until the final status write
//
// Register map (bytes): 0 thread_id, 4 status, 8 control,
//   12 + BYTES_PER_COMMAND*k + BYTES_PER_WORD*w = word w of command k.
// Status word: bit0 busy, bit1 done, [15:8] issued-command count.

module thread_command_sequencer #(
    parameter int unsigned BYTES_PER_WORD    = 4,
    parameter int unsigned COMMAND_COUNT     = 4,
    parameter int unsigned BYTES_PER_COMMAND = 12,
    localparam int unsigned WORD_BITS        = 8 * BYTES_PER_WORD,
    localparam int unsigned ADDR_BITS        = $clog2(12 + BYTES_PER_COMMAND * COMMAND_COUNT)
) (
    input  logic                      clk,
    input  logic                      reset,
    output logic [ADDR_BITS-1:0]      port_b_address,
    output logic                      port_b_rd_en,
    input  logic [WORD_BITS-1:0]      port_b_rd_data,
    output logic [WORD_BITS-1:0]      port_b_wr_data,
    output logic [BYTES_PER_WORD-1:0] port_b_wr_en,
    output logic                      cmd_valid,
    input  logic                      cmd_ready,
    output logic [3*WORD_BITS-1:0]    cmd_data,
    output logic                      busy
);

    localparam int unsigned K_BITS        = (COMMAND_COUNT > 1) ? $clog2(COMMAND_COUNT) : 1;
    localparam int unsigned STATUS_ADDR   = 4;
    localparam int unsigned CONTROL_ADDR  = 8;
    localparam int unsigned CMD_BASE_ADDR = 12;

    localparam logic [ADDR_BITS-1:0] STATUS_A  = ADDR_BITS'(STATUS_ADDR);
    localparam logic [ADDR_BITS-1:0] CONTROL_A = ADDR_BITS'(CONTROL_ADDR);
    localparam logic [K_BITS-1:0]    LAST_K    = K_BITS'(COMMAND_COUNT - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_POLL,
        S_CLEAR,
        S_SET_BUSY,
        S_FETCH,
        S_FETCH_LAST,
        S_ISSUE,
        S_UPDATE,
        S_FINISH
    } state_t;

    state_t state_q, state_d;

    logic [ADDR_BITS-1:0]      addr_d;
    logic                      rd_en_d;
    logic [BYTES_PER_WORD-1:0] wr_en_d;
    logic [WORD_BITS-1:0]      wr_data_d;
    logic                      cmd_valid_d;
    logic [3*WORD_BITS-1:0]    cmd_data_d;
    logic                      busy_d;

    logic [K_BITS-1:0]    k_q, k_d;
    logic [1:0]           w_q, w_d;
    logic [7:0]           count_q, count_d;
    logic [WORD_BITS-1:0] word0_q, word0_d;
    logic [WORD_BITS-1:0] word1_q, word1_d;

    // Byte address of word w of command slot k.
    function automatic logic [ADDR_BITS-1:0] slot_addr(input logic [K_BITS-1:0] k,
                                                       input logic [1:0]        w);
        return ADDR_BITS'(CMD_BASE_ADDR + BYTES_PER_COMMAND * 32'(k) + BYTES_PER_WORD * 32'(w));
    endfunction

    // Status word image: count in [15:8], done in bit1, busy in bit0.
    function automatic logic [WORD_BITS-1:0] status_word(input logic [7:0] count,
                                                         input logic       done);
        return WORD_BITS'({count, 6'b000000, done, ~done});
    endfunction

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and next-output logic. Every port output is registered and
    // loaded with the value that belongs to the state being entered, so the
    // outputs listed for a state are the ones visible during that state.
    always_comb begin
        state_d     = state_q;
        addr_d      = port_b_address;
        rd_en_d     = 1'b0;
        wr_en_d     = '0;
        wr_data_d   = port_b_wr_data;
        cmd_valid_d = 1'b0;
        cmd_data_d  = cmd_data;
        busy_d      = busy;
        k_d         = k_q;
        w_d         = w_q;
        count_d     = count_q;
        word0_d     = word0_q;
        word1_d     = word1_q;

        case (state_q)
            S_IDLE: begin
                addr_d = CONTROL_A;
                if (port_b_rd_en) begin
                    state_d = S_POLL;
                end else begin
                    // Straight out of reset the strobe is still low; issue the
                    // control read now so POLL never samples stale data.
                    rd_en_d = 1'b1;
                end
            end

            S_POLL: begin
                if (port_b_rd_data[0]) begin
                    state_d   = S_CLEAR;
                    addr_d    = CONTROL_A;
                    wr_en_d   = BYTES_PER_WORD'(1);
                    wr_data_d = {port_b_rd_data[WORD_BITS-1:1], 1'b0};
                end else begin
                    state_d = S_IDLE;
                    addr_d  = CONTROL_A;
                    rd_en_d = 1'b1;
                end
            end

            S_CLEAR: begin
                state_d   = S_SET_BUSY;
                addr_d    = STATUS_A;
                wr_en_d   = '1;
                wr_data_d = status_word(8'd0, 1'b0);
                busy_d    = 1'b1;
                k_d       = '0;
                count_d   = '0;
            end

            S_SET_BUSY: begin
                state_d = S_FETCH;
                w_d     = 2'd0;
                rd_en_d = 1'b1;
                addr_d  = slot_addr(k_q, 2'd0);
            end

            S_FETCH: begin
                // Data for the read issued last cycle lands now.
                if (w_q == 2'd1) begin
                    word0_d = port_b_rd_data;
                end
                if (w_q == 2'd2) begin
                    word1_d = port_b_rd_data;
                    state_d = S_FETCH_LAST;
                end else begin
                    w_d     = w_q + 2'd1;
                    rd_en_d = 1'b1;
                    addr_d  = slot_addr(k_q, w_q + 2'd1);
                end
            end

            S_FETCH_LAST: begin
                if (word0_q[7:0] == 8'h00) begin
                    // END opcode: report completion without issuing.
                    state_d   = S_FINISH;
                    addr_d    = STATUS_A;
                    wr_en_d   = '1;
                    wr_data_d = status_word(count_q, 1'b1);
                    busy_d    = 1'b0;
                end else begin
                    state_d     = S_ISSUE;
                    cmd_valid_d = 1'b1;
                    cmd_data_d  = {port_b_rd_data, word1_q, word0_q};
                end
            end

            S_ISSUE: begin
                if (cmd_ready) begin
                    state_d   = S_UPDATE;
                    count_d   = count_q + 8'd1;
                    addr_d    = STATUS_A;
                    wr_en_d   = '1;
                    wr_data_d = status_word(count_q + 8'd1, 1'b0);
                end else begin
                    cmd_valid_d = 1'b1;
                end
            end

            S_UPDATE: begin
                if (k_q == LAST_K) begin
                    state_d   = S_FINISH;
                    addr_d    = STATUS_A;
                    wr_en_d   = '1;
                    wr_data_d = status_word(count_q, 1'b1);
                    busy_d    = 1'b0;
                end else begin
                    state_d = S_FETCH;
                    k_d     = k_q + K_BITS'(1);
                    w_d     = 2'd0;
                    rd_en_d = 1'b1;
                    addr_d  = slot_addr(k_q + K_BITS'(1), 2'd0);
                end
            end

            S_FINISH: begin
                state_d = S_IDLE;
                addr_d  = CONTROL_A;
                rd_en_d = 1'b1;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            port_b_address <= '0;
            port_b_rd_en   <= 1'b0;
            port_b_wr_en   <= '0;
            port_b_wr_data <= '0;
            cmd_valid      <= 1'b0;
            cmd_data       <= '0;
            busy           <= 1'b0;
            k_q            <= '0;
            w_q            <= '0;
            count_q        <= '0;
            word0_q        <= '0;
            word1_q        <= '0;
        end else begin
            port_b_address <= addr_d;
            port_b_rd_en   <= rd_en_d;
            port_b_wr_en   <= wr_en_d;
            port_b_wr_data <= wr_data_d;
            cmd_valid      <= cmd_valid_d;
            cmd_data       <= cmd_data_d;
            busy           <= busy_d;
            k_q            <= k_d;
            w_q            <= w_d;
            count_q        <= count_d;
            word0_q        <= word0_d;
            word1_q        <= word1_d;
        end
    end

endmodule

// File: tb/tb_thread_command_sequencer.sv
// Directed bench for thread_command_sequencer with a behavioural register
// block on port B and a CPU-side write port for loading commands.

module tb_thread_command_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  port_b_address;
    logic        port_b_rd_en;
    logic [31:0] port_b_rd_data;
    logic [31:0] port_b_wr_data;
    logic [3:0]  port_b_wr_en;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [95:0] cmd_data;
    logic        busy;

    thread_command_sequencer #(
        .BYTES_PER_WORD   (4),
        .COMMAND_COUNT    (4),
        .BYTES_PER_COMMAND(12)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .port_b_address(port_b_address),
        .port_b_rd_en  (port_b_rd_en),
        .port_b_rd_data(port_b_rd_data),
        .port_b_wr_data(port_b_wr_data),
        .port_b_wr_en  (port_b_wr_en),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_data      (cmd_data),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // Register block: 15 words, 1-cycle read latency, byte-enabled writes.
    logic [31:0] mem [0:14];
    logic        cpu_we;
    logic [3:0]  cpu_idx;
    logic [31:0] cpu_data;

    always @(posedge clk) begin
        if (port_b_rd_en)
            port_b_rd_data <= (port_b_address[5:2] < 4'd15) ? mem[port_b_address[5:2]] : 32'h0;
        for (int b = 0; b < 4; b++)
            if (port_b_wr_en[b] && port_b_address[5:2] < 4'd15)
                mem[port_b_address[5:2]][8*b +: 8] <= port_b_wr_data[8*b +: 8];
        if (cpu_we)
            mem[cpu_idx] <= cpu_data;
    end

    // Bus monitor, sampled mid-cycle.
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          conflicts;
    int          done_cnt = 0;
    int          first_rd_cyc;
    int          first_fetch_addr;
    int          slot_reads [4];
    logic [95:0] issue_q [$];
    logic [31:0] status_q [$];
    int          rise_q [$];
    logic        prev_valid = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (!reset) begin
            if (port_b_rd_en && port_b_wr_en != 4'h0) conflicts++;
            if (port_b_rd_en && port_b_address >= 6'd12) begin
                slot_reads[(int'(port_b_address) - 12) / 12]++;
                if (first_fetch_addr < 0) first_fetch_addr = int'(port_b_address);
            end
            if (port_b_rd_en && first_rd_cyc < 0) first_rd_cyc = cyc;
            if (port_b_wr_en == 4'hF && port_b_address == 6'd4) begin
                status_q.push_back(port_b_wr_data);
                if (port_b_wr_data[1]) done_cnt++;
            end
            if (cmd_valid && cmd_ready) issue_q.push_back(cmd_data);
            if (cmd_valid && !prev_valid) rise_q.push_back(cyc);
        end
        prev_valid = cmd_valid;
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [95:0] iss(input int i);
        return (i < issue_q.size()) ? issue_q[i] : 96'bx;
    endfunction

    function automatic logic [31:0] st(input int i);
        return (i >= 0 && i < status_q.size()) ? status_q[i] : 32'bx;
    endfunction

    function automatic logic [31:0] last_status();
        return st(status_q.size() - 1);
    endfunction

    function automatic int rise(input int i);
        return (i < rise_q.size()) ? rise_q[i] : -1000;
    endfunction

    function automatic logic [95:0] exp_cmd(input int k, input logic [7:0] op);
        return {32'h2222_0000 + 32'(k), 32'h1111_0000 + 32'(k), 16'hC0DE, 8'(k), op};
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic cpu_write(input int idx, input logic [31:0] data);
        cpu_idx  = 4'(idx);
        cpu_data = data;
        cpu_we   = 1'b1;
        step(1);
        cpu_we   = 1'b0;
    endtask

    task automatic load_cmd(input int k, input logic [7:0] op);
        logic [95:0] c;
        c = exp_cmd(k, op);
        cpu_write(3 + 3*k, c[31:0]);
        cpu_write(4 + 3*k, c[63:32]);
        cpu_write(5 + 3*k, c[95:64]);
    endtask

    task automatic clear_mon();
        conflicts        = 0;
        first_rd_cyc     = -1;
        first_fetch_addr = -1;
        for (int i = 0; i < 4; i++) slot_reads[i] = 0;
        issue_q.delete();
        status_q.delete();
        rise_q.delete();
    endtask

    task automatic wait_finish(input int budget);
        int n0;
        int i;
        n0 = done_cnt;
        i  = 0;
        while (done_cnt == n0 && i < budget) begin
            step(1);
            i++;
        end
        check("finish_seen", done_cnt != n0, 1'b1);
        step(2);
    endtask

    task automatic wait_valid(input int budget);
        int i;
        i = 0;
        @(negedge clk);
        while (!cmd_valid && i < budget) begin
            @(negedge clk);
            i++;
        end
        check("valid_seen", cmd_valid, 1'b1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_st [6];
        logic [95:0] held;
        int viol, rds, polls, wrs, r, c;
        logic prev_rd;

        reset     = 1'b1;
        cmd_ready = 1'b1;
        cpu_we    = 1'b0;
        cpu_idx   = '0;
        cpu_data  = '0;
        clear_mon();
        step(1);

        // ---- Full list, start already set when reset releases ----
        cpu_write(0, 32'h0000_0007);
        cpu_write(1, 32'h0);
        cpu_write(2, 32'h1);
        load_cmd(0, 8'h11);
        load_cmd(1, 8'h22);
        load_cmd(2, 8'h33);
        load_cmd(3, 8'h44);
        @(negedge clk);
        check("rst_rd_en", port_b_rd_en, 1'b0);
        check("rst_wr_en", port_b_wr_en, 4'h0);
        check("rst_cmd_valid", cmd_valid, 1'b0);
        check("rst_cmd_data", cmd_data, 96'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_addr", port_b_address, 6'd0);
        check("rst_wr_data", port_b_wr_data, 32'h0);
        @(posedge clk);
        #1;
        clear_mon();
        reset = 1'b0;
        wait_finish(200);
        check("full_issues", issue_q.size(), 4);
        for (int k = 0; k < 4; k++)
            check($sformatf("full_cmd%0d", k), iss(k), exp_cmd(k, 8'h11 * 8'(k + 1)));
        exp_st = '{32'h1, 32'h101, 32'h201, 32'h301, 32'h401, 32'h402};
        check("full_status_n", status_q.size(), 6);
        for (int i = 0; i < 6; i++)
            check($sformatf("full_status%0d", i), st(i), exp_st[i]);
        check("lat_first", rise(0) - first_rd_cyc, 8);
        check("lat_next", rise(1) - rise(0), 6);
        check("full_control", mem[2], 32'h0);
        check("full_status_mem", mem[1], 32'h402);
        check("full_busy", busy, 1'b0);
        check("full_conflict", conflicts, 0);

        // ---- Early END in slot 1 ----
        load_cmd(1, 8'h00);
        clear_mon();
        cpu_write(2, 32'h1);
        wait_finish(200);
        check("end_issues", issue_q.size(), 1);
        check("end_cmd0", iss(0), exp_cmd(0, 8'h11));
        check("end_status_n", status_q.size(), 3);
        check("end_final", last_status(), 32'h102);
        check("end_slot1_reads", slot_reads[1], 3);
        check("end_slot2_reads", slot_reads[2], 0);
        check("end_slot3_reads", slot_reads[3], 0);

        // ---- Backpressure on the first command ----
        load_cmd(1, 8'h22);
        cmd_ready = 1'b0;
        clear_mon();
        cpu_write(2, 32'h1);
        wait_valid(40);
        held = cmd_data;
        viol = 0;
        repeat (5) begin
            @(negedge clk);
            if (!cmd_valid || cmd_data !== held || port_b_rd_en || port_b_wr_en != 4'h0) viol++;
        end
        check("bp_hold", viol, 0);
        @(posedge clk);
        #1;
        check("bp_no_hs", issue_q.size(), 0);
        cmd_ready = 1'b1;
        step(2);
        check("bp_one_hs", issue_q.size(), 1);
        check("bp_cmd0", iss(0), exp_cmd(0, 8'h11));
        wait_finish(200);
        check("bp_issues", issue_q.size(), 4);
        check("bp_cmd1", iss(1), exp_cmd(1, 8'h22));
        check("bp_final", last_status(), 32'h402);
        check("bp_conflict", conflicts, 0);

        // ---- Control byte preservation ----
        clear_mon();
        cpu_write(2, 32'hA5A5_00F3);
        wait_finish(200);
        check("ctl_preserve", mem[2], 32'hA5A5_00F2);
        check("ctl_issues", issue_q.size(), 4);

        // ---- Idle polling, then a late start ----
        clear_mon();
        step(2);
        viol = 0;
        rds  = 0;
        @(negedge clk);
        prev_rd = port_b_rd_en;
        repeat (10) begin
            @(negedge clk);
            if (port_b_rd_en) rds++;
            if (port_b_rd_en == prev_rd) viol++;
            if (port_b_rd_en && port_b_address != 6'd8) viol++;
            if (port_b_wr_en != 4'h0 || cmd_valid) viol++;
            prev_rd = port_b_rd_en;
        end
        check("idle_reads", rds, 5);
        check("idle_pattern", viol, 0);
        @(posedge clk);
        #1;
        cpu_write(2, 32'h1);
        r = -1;
        c = -1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (r < 0 && port_b_rd_en && port_b_address == 6'd8) r = i;
            if (c < 0 && port_b_wr_en != 4'h0) c = i;
        end
        check("start_pickup", (r >= 1 && r <= 2), 1'b1);
        check("start_clear", c - r, 2);
        wait_finish(200);
        check("late_issues", issue_q.size(), 4);

        // ---- Reset while a command is waiting in ISSUE ----
        cmd_ready = 1'b0;
        clear_mon();
        cpu_write(2, 32'h1);
        wait_valid(40);
        check("mid_status_busy", mem[1], 32'h1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        @(negedge clk);
        check("mid_valid_drop", cmd_valid, 1'b0);
        check("mid_busy_drop", busy, 1'b0);
        polls = 0;
        wrs   = 0;
        repeat (6) begin
            @(negedge clk);
            if (port_b_rd_en && port_b_address == 6'd8) polls++;
            if (port_b_wr_en != 4'h0) wrs++;
        end
        check("mid_polling", polls >= 2, 1'b1);
        check("mid_no_write", wrs, 0);
        check("mid_status_kept", mem[1], 32'h1);
        @(posedge clk);
        #1;
        clear_mon();
        cmd_ready = 1'b1;
        cpu_write(2, 32'h1);
        wait_finish(200);
        check("restart_first_fetch", first_fetch_addr, 12);
        check("restart_issues", issue_q.size(), 4);
        check("restart_cmd0", iss(0), exp_cmd(0, 8'h11));
        check("restart_final", last_status(), 32'h402);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/thread_command_sequencer.md
Name: thread_command_sequencer

Overview:
GPU-side consumer of one thread's register block. It drives that block's port B to poll the control word for a start request, clears the request, and marks the thread busy. It then fetches the command list one 3-word command at a time, presents each command to the execution pipeline over a valid/ready handshake, and writes progress and completion back into the status word.

Parameters:
BYTES_PER_WORD, 4, bytes per register word; WORD_BITS = 8*BYTES_PER_WORD.
COMMAND_COUNT, 4, number of command slots in the register block.
BYTES_PER_COMMAND, 12, bytes per command slot; fixed at 3 words.
ADDR_BITS (localparam), $clog2(12+BYTES_PER_COMMAND*COMMAND_COUNT), width of the register-block byte address.

Ports:
clk  in  1  single clock; the register block's port B clock is tied to it.
reset  in  1  synchronous, active-high.
port_b_address  out  ADDR_BITS  byte address into the register block.
port_b_rd_en  out  1  read strobe; data returns 1 cycle later.
port_b_rd_data  in  WORD_BITS  read data from the register block.
port_b_wr_data  out  WORD_BITS  write data.
port_b_wr_en  out  BYTES_PER_WORD  per-byte write enables.
cmd_valid  out  1  command presented to the execution pipeline.
cmd_ready  in  1  execution pipeline accepts the command.
cmd_data  out  3*WORD_BITS  command payload: word0 in [31:0], word1 in [63:32], word2 in [95:64].
busy  out  1  high from the start-bit clear until the final status write.

Behaviour:
- Register map (byte addresses): 0 thread_id, 4 status, 8 control, 12+12k+4w = word w of command k.
- Port B timing and access rules:
  - Read data is valid on the cycle after rd_en.
  - Exactly one access per cycle: never assert rd_en and any wr_en together.
  - Address must be held valid in the access cycle.
- Status word format: bit0 busy, bit1 done, [15:8] issued-command count, all other bits 0.
- Control word format: bit0 start; other bits are ignored and preserved.
- Reset values: state IDLE, rd_en 0, wr_en 0, cmd_valid 0, cmd_data 0, busy 0, address 0, wr_data 0, internal k/count 0.
- Reset mid-operation drops cmd_valid immediately and writes nothing back to status.
- State machine:
  - IDLE: rd_en=1, address=8 -> POLL.
  - POLL: sample rd_data. If bit0=1 -> CLEAR; else -> IDLE (so control is read every 2 cycles).
  - CLEAR: address=8, wr_en=0001, wr_data[7:0] = sampled control[7:0] with bit0 forced to 0 -> SET_BUSY.
  - SET_BUSY: address=4, wr_en=all ones, wr_data=0x00000001, busy goes 1, k=0, count=0 -> FETCH.
  - FETCH (3 cycles, w=0,1,2): rd_en=1, address=12+12k+4w. rd_data from the previous cycle is captured into word w-1 -> FETCH_LAST.
  - FETCH_LAST: capture word2. If word0[7:0]==0 (END opcode) -> FINISH without issuing; else -> ISSUE.
  - ISSUE: cmd_valid=1; cmd_data stays stable until cmd_ready. On valid&&ready, count++ -> UPDATE.
  - UPDATE: write status = {count<<8 | 0x1}. If k==COMMAND_COUNT-1 -> FINISH; else k++ -> FETCH.
  - FINISH: write status = {count<<8 | 0x2}, busy goes 0 -> IDLE.
- A start bit set while busy is not sampled until the sequencer returns to IDLE. It is never lost because only CLEAR clears it.
- The CPU may overwrite a command slot during fetch; whatever words were read are issued as-is, with no coherency check.
- count is 8 bits; COMMAND_COUNT must be <=255.
- Latency, reset deasserted with start already set:
  - cmd_valid first rises 8 cycles after the first IDLE cycle.
  - With cmd_ready held high, subsequent commands issue every 6 cycles.

Test Plan:
- Full list: control=0x1; commands with opcodes 0x11,0x22,0x33,0x44; cmd_ready=1 -> four issues in order, cmd_data word order correct, status sequence 0x101, 0x201, 0x301, 0x401, then final 0x402; control reads 0x0; busy low.
- Early END: slot1 opcode 0 -> one issue (0x11), final status 0x102; slot2/slot3 never read.
- Backpressure: cmd_ready low for 5 cycles during ISSUE -> cmd_valid and cmd_data held stable, no reads or writes on port B meanwhile, and exactly one handshake when ready rises.
- Control byte preservation: control=0xA5A5_00F3 -> after CLEAR, control reads 0xA5A5_00F2.
- Idle polling: control=0 -> rd_en toggles every other cycle at address 8; never wr_en, never cmd_valid. Setting start later begins the sequence within 2 cycles of the write.
- Reset mid-ISSUE: reset pulsed for 1 cycle -> cmd_valid=0 next cycle, status unchanged (still 0x001 busy), sequencer back to polling; a fresh start restarts from slot 0.
